// File: rtl/ysyx_040729_pipe_ctrl.sv
// Pipeline hazard/stall controller: derives PC and pipeline-register load/flush enables
// from fetch, hazard, busy and redirect conditions, with a stall counter and hazard timeout flag.
module ysyx_040729_pipe_ctrl #(
  parameter int unsigned HAZARD_MAX = 2,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ifu_valid_i,
  input  logic                 mem_hazard_i,
  input  logic                 exu_busy_i,
  input  logic                 lsu_busy_i,
  input  logic                 system_jump_i,
  input  logic                 redirect_i,
  output logic                 pc_we_o,
  output logic                 ifid_we_o,
  output logic                 idex_we_o,
  output logic                 exmem_we_o,
  output logic                 ifid_flush_o,
  output logic                 idex_flush_o,
  output logic [1:0]           state_o,
  output logic                 hazard_err_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StHaz   = 2'b01,
    StBusy  = 2'b10,
    StRedir = 2'b11
  } state_e;

  localparam int unsigned HcntW = (HAZARD_MAX > 1) ? $clog2(HAZARD_MAX) : 1;
  localparam logic [HcntW-1:0] HcntLoad = HcntW'(HAZARD_MAX - 1);

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [HcntW-1:0]     hcnt_q, hcnt_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush;
  logic jump_go, run_rules;

  // A pending or fresh jump waits only for the LSU to drain.
  assign jump_go = (system_jump_i | pend_q) & ~lsu_busy_i;

  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    idex_we    = 1'b0;
    exmem_we   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    pend_d     = pend_q;
    hcnt_d     = hcnt_q;
    err_d      = err_q;
    run_rules  = 1'b0;

    if (jump_go) begin
      pc_we      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_we   = 1'b1;
      pend_d     = 1'b0;
      hcnt_d     = '0;
      state_d    = StRedir;
    end else if (exu_busy_i || lsu_busy_i) begin
      if (system_jump_i) pend_d = 1'b1;
      state_d = StBusy;
    end else begin
      unique case (state_q)
        StHaz: begin
          if (mem_hazard_i) begin
            idex_flush = 1'b1;
            exmem_we   = 1'b1;
            if (hcnt_q == '0) err_d = 1'b1;
            else hcnt_d = hcnt_q - 1'b1;
          end else begin
            run_rules = 1'b1;
          end
        end
        StRedir: begin
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          if (ifu_valid_i) begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            state_d = StRun;
          end else begin
            ifid_flush = 1'b1;
          end
        end
        default: run_rules = 1'b1;
      endcase

      if (run_rules) begin
        state_d = StRun;
        if (mem_hazard_i) begin
          idex_flush = 1'b1;
          exmem_we   = 1'b1;
          hcnt_d     = HcntLoad;
          state_d    = StHaz;
        end else if (redirect_i && ifu_valid_i) begin
          pc_we      = 1'b1;
          ifid_flush = 1'b1;
          idex_we    = 1'b1;
          exmem_we   = 1'b1;
          state_d    = StRedir;
        end else if (!ifu_valid_i) begin
          ifid_flush = 1'b1;
          idex_we    = 1'b1;
          exmem_we   = 1'b1;
        end else begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
        end
      end
    end
  end

  // Saturating count of cycles without a PC load.
  always_comb begin
    stall_d = stall_q;
    if (!pc_we && (stall_q != '1)) stall_d = stall_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      pend_q  <= 1'b0;
      hcnt_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hcnt_q  <= hcnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  // Reset forces bubbles into both front registers and blocks every load.
  assign pc_we_o        = reset & pc_we;
  assign ifid_we_o      = reset & ifid_we;
  assign idex_we_o      = reset & idex_we;
  assign exmem_we_o     = reset & exmem_we;
  assign ifid_flush_o   = ~reset | ifid_flush;
  assign idex_flush_o   = ~reset | idex_flush;
  assign state_o        = state_q;
  assign hazard_err_o   = err_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_ysyx_040729_pipe_ctrl.sv
// Bench for ysyx_040729_pipe_ctrl: directed vector table, reset/saturation sequences,
// and randomized traffic against a behavioural model.
module tb_ysyx_040729_pipe_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ifu_valid_i, mem_hazard_i, exu_busy_i, lsu_busy_i, system_jump_i, redirect_i;

  logic        pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, ifid_flush_o, idex_flush_o;
  logic [1:0]  state_o;
  logic        hazard_err_o;
  logic [31:0] stall_cycles_o;

  logic        s_pc_we, s_ifid_we, s_idex_we, s_exmem_we, s_ifid_flush, s_idex_flush;
  logic [1:0]  s_state;
  logic        s_err;
  logic [3:0]  s_stall;

  always #5 clock = ~clock;

  ysyx_040729_pipe_ctrl #(.HAZARD_MAX(2), .CNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .ifu_valid_i(ifu_valid_i), .mem_hazard_i(mem_hazard_i), .exu_busy_i(exu_busy_i),
    .lsu_busy_i(lsu_busy_i), .system_jump_i(system_jump_i), .redirect_i(redirect_i),
    .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .idex_we_o(idex_we_o), .exmem_we_o(exmem_we_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .state_o(state_o),
    .hazard_err_o(hazard_err_o), .stall_cycles_o(stall_cycles_o)
  );

  // Narrow-counter instance sharing the same stimulus.
  ysyx_040729_pipe_ctrl #(.HAZARD_MAX(2), .CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset),
    .ifu_valid_i(ifu_valid_i), .mem_hazard_i(mem_hazard_i), .exu_busy_i(exu_busy_i),
    .lsu_busy_i(lsu_busy_i), .system_jump_i(system_jump_i), .redirect_i(redirect_i),
    .pc_we_o(s_pc_we), .ifid_we_o(s_ifid_we), .idex_we_o(s_idex_we), .exmem_we_o(s_exmem_we),
    .ifid_flush_o(s_ifid_flush), .idex_flush_o(s_idex_flush), .state_o(s_state),
    .hazard_err_o(s_err), .stall_cycles_o(s_stall)
  );

  logic [5:0] outs;
  assign outs = {pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, ifid_flush_o, idex_flush_o};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs packed as {ifu_valid, mem_hazard, exu_busy, lsu_busy, system_jump, redirect}.
  task automatic drive(input logic [5:0] v);
    {ifu_valid_i, mem_hazard_i, exu_busy_i, lsu_busy_i, system_jump_i, redirect_i} = v;
  endtask

  // Outputs packed as {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush}.
  typedef struct {
    logic [5:0] in;
    logic [5:0] out;
    int         st;
    int         stall;
    int         err;
  } vec_t;

  vec_t tbl[22];

  // Behavioural model: modes 0 run, 1 load-use wait, 2 frozen, 3 refetch after redirect.
  int     m_mode, m_pend, m_left, m_err;
  longint m_stall, m_stall4;
  int     n_mode, n_pend, n_left, n_err;
  logic [5:0] m_out;

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_left = 0; m_err = 0; m_stall = 0; m_stall4 = 0;
  endtask

  task automatic model_eval(input logic [5:0] v);
    bit valid, haz, exu, lsu, jmp, redir, go, normal;
    {valid, haz, exu, lsu, jmp, redir} = v;
    n_mode = m_mode; n_pend = m_pend; n_left = m_left; n_err = m_err;
    go = (jmp || m_pend != 0) && !lsu;
    normal = 0;
    if (go) begin
      m_out = 6'b100111; n_mode = 3; n_pend = 0; n_left = 0;
    end else if (exu || lsu) begin
      m_out = 6'b000000; n_mode = 2;
      if (jmp) n_pend = 1;
    end else if (m_mode == 1 && haz) begin
      m_out = 6'b000101;
      if (m_left == 0) n_err = 1;
      else n_left = m_left - 1;
    end else if (m_mode == 3) begin
      m_out = valid ? 6'b111100 : 6'b001110;
      n_mode = valid ? 0 : 3;
    end else begin
      normal = 1;
    end
    if (normal) begin
      n_mode = 0;
      if (haz) begin
        m_out = 6'b000101; n_left = 2 - 1; n_mode = 1;
      end else if (redir && valid) begin
        m_out = 6'b101110; n_mode = 3;
      end else if (!valid) begin
        m_out = 6'b001110;
      end else begin
        m_out = 6'b111100;
      end
    end
  endtask

  task automatic model_commit();
    m_mode = n_mode; m_pend = n_pend; m_left = n_left; m_err = n_err;
    if (m_out[5] == 1'b0) begin
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end
  endtask

  initial begin
    tbl[0]  = '{6'b100000, 6'b111100, 0, 0,  0};
    tbl[1]  = '{6'b110000, 6'b000101, 1, 1,  0};
    tbl[2]  = '{6'b110000, 6'b000101, 1, 2,  0};
    tbl[3]  = '{6'b100000, 6'b111100, 0, 2,  0};
    tbl[4]  = '{6'b100001, 6'b101110, 3, 2,  0};
    tbl[5]  = '{6'b000000, 6'b001110, 3, 3,  0};
    tbl[6]  = '{6'b000000, 6'b001110, 3, 4,  0};
    tbl[7]  = '{6'b100000, 6'b111100, 0, 4,  0};
    tbl[8]  = '{6'b100110, 6'b000000, 2, 5,  0};
    tbl[9]  = '{6'b100100, 6'b000000, 2, 6,  0};
    tbl[10] = '{6'b100100, 6'b000000, 2, 7,  0};
    tbl[11] = '{6'b100000, 6'b100111, 3, 7,  0};
    tbl[12] = '{6'b100000, 6'b111100, 0, 7,  0};
    tbl[13] = '{6'b000000, 6'b001110, 0, 8,  0};
    tbl[14] = '{6'b101000, 6'b000000, 2, 9,  0};
    tbl[15] = '{6'b110000, 6'b000101, 1, 10, 0};
    tbl[16] = '{6'b110000, 6'b000101, 1, 11, 0};
    tbl[17] = '{6'b110000, 6'b000101, 1, 12, 1};
    tbl[18] = '{6'b110000, 6'b000101, 1, 13, 1};
    tbl[19] = '{6'b100000, 6'b111100, 0, 13, 1};
    tbl[20] = '{6'b100010, 6'b100111, 3, 13, 1};
    tbl[21] = '{6'b100000, 6'b111100, 0, 13, 1};

    drive(6'b100000);
    repeat (2) @(posedge clock);
    #1;
    check("reset_outs", outs, 6'b000011);
    check("reset_state", state_o, 0);
    check("reset_stall", stall_cycles_o, 0);
    check("reset_err", hazard_err_o, 0);
    @(negedge clock) reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clock);
      drive(tbl[i].in);
      #1;
      check($sformatf("tbl%0d_outs", i), outs, tbl[i].out);
      @(posedge clock);
      #1;
      check($sformatf("tbl%0d_state", i), state_o, tbl[i].st);
      check($sformatf("tbl%0d_stall", i), stall_cycles_o, tbl[i].stall);
      check($sformatf("tbl%0d_stall4", i), s_stall, tbl[i].stall);
      check($sformatf("tbl%0d_err", i), hazard_err_o, tbl[i].err);
    end

    // Twenty fetch bubbles: the 4-bit counter must pin at 15.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      drive(6'b000000);
    end
    @(posedge clock);
    #1;
    check("sat_stall4", s_stall, 15);
    check("sat_stall32", stall_cycles_o, 33);

    // Asynchronous reset while frozen.
    @(negedge clock);
    drive(6'b101000);
    @(posedge clock);
    #1;
    check("busy_state", state_o, 2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_outs", outs, 6'b000011);
    check("async_rst_state", state_o, 0);
    check("async_rst_stall", stall_cycles_o, 0);
    check("async_rst_stall4", s_stall, 0);
    check("async_rst_err", hazard_err_o, 0);
    @(negedge clock) drive(6'b100000);
    @(negedge clock) reset = 1'b1;
    model_reset();

    for (int blk = 0; blk < 4; blk++) begin
      for (int c = 0; c < 100; c++) begin
        logic [5:0] v;
        @(negedge clock);
        v[5] = ($urandom_range(0, 3) != 0);
        v[4] = ($urandom_range(0, 2) == 0);
        v[3] = ($urandom_range(0, 7) == 0);
        v[2] = ($urandom_range(0, 5) == 0);
        v[1] = ($urandom_range(0, 9) == 0);
        v[0] = ($urandom_range(0, 3) == 0);
        drive(v);
        #1;
        model_eval(v);
        check("rnd_outs", outs, m_out);
        check("rnd_state", state_o, m_mode);
        check("rnd_err", hazard_err_o, m_err);
        check("rnd_stall", stall_cycles_o, m_stall);
        check("rnd_stall4", s_stall, m_stall4);
        @(posedge clock);
        model_commit();
      end
      @(negedge clock);
      drive(6'b100000);
      reset = 1'b0;
      model_reset();
      @(negedge clock) reset = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_040729_pipe_ctrl.md
YSYX_040729_PIPE_CTRL -- requirements
Module: ysyx_040729_pipe_ctrl

Interface
REQ-001 SHALL have parameter HAZARD_MAX, default 2: maximum load-use stall cycles before hazard_err_o sets.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of stall_cycles_o.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is asynchronous and active-low (0 = reset asserted).
REQ-005 SHALL have port ifu_valid_i, input, 1: fetched instruction present at IF/ID input.
REQ-006 SHALL have port mem_hazard_i, input, 1: IDU branch/CSR-write operand depends on a load not yet returned.
REQ-007 SHALL have port exu_busy_i, input, 1: multi-cycle EXU op incomplete.
REQ-008 SHALL have port lsu_busy_i, input, 1: LSU access outstanding.
REQ-009 SHALL have port system_jump_i, input, 1: trap/mret redirect request, single-cycle pulse.
REQ-010 SHALL have port redirect_i, input, 1: IDU npc differs from pc+4 (taken branch/jump).
REQ-011 SHALL have port pc_we_o, output, 1: PC register load enable.
REQ-012 SHALL have ports ifid_we_o, idex_we_o and exmem_we_o, each output, 1: pipeline-register load enables.
REQ-013 SHALL have ports ifid_flush_o and idex_flush_o, each output, 1: load a bubble into that register (dominates its _we).
REQ-014 SHALL have port state_o, output, 2: FSM state, with RUN=00, HAZ=01, BUSY=10, REDIR=11.
REQ-015 SHALL have port hazard_err_o, output, 1: sticky flag, hazard persisted past HAZARD_MAX.
REQ-016 SHALL have port stall_cycles_o, output, CNT_WIDTH: saturating count of cycles with pc_we_o=0 outside reset.

Function
REQ-017 SHALL evaluate per cycle in priority order: jump handling, busy, hazard, redirect, fetch bubble.
REQ-018 SHALL hold jump_pend on a system_jump_i that arrives while lsu_busy_i=1; the jump executes in the first cycle lsu_busy_i=0.
REQ-019 SHALL, on a jump executing from any state: set pc_we_o=1, ifid_flush_o=1, idex_flush_o=1, exmem_we_o=1; clear jump_pend and hazard count; next state REDIR.
REQ-020 SHALL, when exu_busy_i or lsu_busy_i is 1 (no executing jump): drive all _we and _flush outputs 0 (freeze); next state BUSY; BUSY returns to RUN the first cycle both are 0, applying RUN rules in that cycle.
REQ-021 SHALL, in RUN with mem_hazard_i=1: set pc_we_o=0, ifid_we_o=0, idex_flush_o=1, exmem_we_o=1; load hazard count with HAZARD_MAX-1; next state HAZ.
REQ-022 SHALL, in HAZ: repeat the REQ-021 outputs while mem_hazard_i=1 and decrement the count, saturating at 0; if mem_hazard_i=1 with count 0, set hazard_err_o and stay in HAZ; go to RUN with RUN outputs when mem_hazard_i=0.
REQ-023 SHALL, in RUN with redirect_i=1 and ifu_valid_i=1: set pc_we_o=1, ifid_flush_o=1, idex_we_o=1, exmem_we_o=1; next state REDIR.
REQ-024 SHALL, in REDIR: keep ifid_flush_o=1 and pc_we_o=0 until ifu_valid_i=1; in that cycle set pc_we_o=1 and ifid_we_o=1 and go to RUN; idex_we_o and exmem_we_o stay 1 throughout.
REQ-025 SHALL, in RUN with ifu_valid_i=0 and nothing else pending: set pc_we_o=0, ifid_flush_o=1, idex_we_o=1, exmem_we_o=1.
REQ-026 SHALL, in RUN with no condition: drive all _we=1 and all _flush=0.
REQ-027 SHALL increment stall_cycles_o by 1 each cycle with pc_we_o=0, saturating at all-ones without wrap.
REQ-028 SHALL keep every output a function of current state and inputs, with no added latency.

Reset
REQ-029 SHALL, while reset=0 (takes effect immediately, mid-operation included): state RUN; jump_pend, hazard count, hazard_err_o and stall_cycles_o at 0; all _we=0; ifid_flush_o=1 and idex_flush_o=1.
REQ-030 SHALL resume RUN rules at the first rising edge after reset returns to 1.

Verification
REQ-031 SHALL cover load-use: mem_hazard_i=1 for 2 cycles, HAZARD_MAX=2 -> 2 cycles pc_we_o=0 and idex_flush_o=1, state 01 then 00, hazard_err_o=0, stall_cycles_o=2.
REQ-032 SHALL cover hazard timeout: mem_hazard_i=1 for 4 cycles -> hazard_err_o=1 from the 3rd cycle and stays 1 after the hazard clears.
REQ-033 SHALL cover jump under LSU busy: system_jump_i pulse with lsu_busy_i=1 for 3 cycles -> outputs frozen 3 cycles, then one cycle pc_we_o=1, ifid_flush_o=1, idex_flush_o=1, state 11.
REQ-034 SHALL cover redirect with slow fetch: redirect_i=1, then ifu_valid_i=0 for 2 cycles -> REDIR with ifid_flush_o=1 for 2 cycles, then ifid_we_o=1 and state 00.
REQ-035 SHALL cover async reset mid-BUSY: reset=0 between clock edges -> outputs reach reset values before the next edge; stall_cycles_o=0.
REQ-036 SHALL cover saturation: CNT_WIDTH=4 and 20 stall cycles -> stall_cycles_o=15, no wrap.
